lock_arbiter_param: RTL and testbench



---
 rtl/lock_arbiter_param.sv | 138 +++++++++++++
 tb/tb_lock_arbiter_param.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/lock_arbiter_param.sv
// N-requester arbiter that locks the grant to its owner while the owner keeps
// requesting. Arbitration is fixed priority (index 0 highest) or round-robin,
// chosen by mode. A hold timeout forces a handover when others are waiting.
module lock_arbiter_param #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned ID_W     = $clog2(N),
    parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            mode,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic            timeout_evt
);

    // Keep the counter at least one bit wide when the timeout is disabled.
    localparam int unsigned HC_W      = (CNT_W == 0) ? 1 : CNT_W;
    localparam int unsigned HOLD_LAST = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]      state,         state_n;
    logic [N-1:0]    grant_n;
    logic            grant_valid_n;
    logic [ID_W-1:0] grant_id_n;
    logic            timeout_evt_n;
    logic [ID_W-1:0] rr_ptr,        rr_ptr_n;
    logic [HC_W-1:0] hold_cnt,      hold_cnt_n;

    logic [N-1:0]    cand;
    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic            owner_hi;
    logic            others_hi;

    // The current grant is the owner mask; candidates always exclude it.
    assign cand      = req & ~grant;
    assign owner_hi  = |(req & grant);
    assign others_hi = |cand;

    // Pick the winner among the candidates: lowest index, or first at/after rr_ptr.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            idx = mode ? ((int'(rr_ptr) + k) % int'(N)) : k;
            if (cand[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            timeout_evt <= 1'b0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            grant_valid <= grant_valid_n;
            grant_id    <= grant_id_n;
            timeout_evt <= timeout_evt_n;
            rr_ptr      <= rr_ptr_n;
            hold_cnt    <= hold_cnt_n;
        end
    end

    // Next-state logic: lock, release with zero bubble, or forced handover.
    always_comb begin
        state_n       = state;
        grant_n       = grant;
        grant_valid_n = grant_valid;
        grant_id_n    = grant_id;
        timeout_evt_n = 1'b0;
        rr_ptr_n      = rr_ptr;
        hold_cnt_n    = hold_cnt;

        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_n       = S_LOCKED;
                    grant_n       = N'(1) << win_id;
                    grant_valid_n = 1'b1;
                    grant_id_n    = win_id;
                    rr_ptr_n      = (win_id == ID_W'(N - 1)) ? '0 : win_id + 1'b1;
                    hold_cnt_n    = '0;
                end
            end
            S_LOCKED: begin
                if (!owner_hi) begin
                    hold_cnt_n = '0;
                    if (win_found) begin
                        grant_n    = N'(1) << win_id;
                        grant_id_n = win_id;
                        rr_ptr_n   = (win_id == ID_W'(N - 1)) ? '0 : win_id + 1'b1;
                    end else begin
                        state_n       = S_IDLE;
                        grant_n       = '0;
                        grant_valid_n = 1'b0;
                        grant_id_n    = '0;
                    end
                end else if (others_hi && (MAX_HOLD != 0) &&
                             (hold_cnt >= HC_W'(HOLD_LAST))) begin
                    // Owner has used its full hold budget and someone is waiting.
                    grant_n       = N'(1) << win_id;
                    grant_id_n    = win_id;
                    rr_ptr_n      = (win_id == ID_W'(N - 1)) ? '0 : win_id + 1'b1;
                    hold_cnt_n    = '0;
                    timeout_evt_n = 1'b1;
                end else if (hold_cnt != HC_W'(MAX_HOLD)) begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_n       = S_IDLE;
                grant_n       = '0;
                grant_valid_n = 1'b0;
                grant_id_n    = '0;
                hold_cnt_n    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_lock_arbiter_param.sv
// Self-checking bench for lock_arbiter_param: directed scenarios followed by
// randomized traffic, all compared every cycle against an ownership model.
module tb_lock_arbiter_param;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_HOLD = 8;
    localparam int unsigned ID_W     = $clog2(N);
    localparam int unsigned CNT_W    = $clog2(MAX_HOLD + 1);

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic            mode;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [ID_W-1:0] grant_id;
    logic            timeout_evt;

    int checks   = 0;
    int failures = 0;

    // Reference model state: who owns the resource and for how many cycles.
    int owner      = -1;
    int held       = 0;
    int rr_next    = 0;
    bit exp_to     = 1'b0;
    int to_seen    = 0;

    lock_arbiter_param #(
        .N(N), .MAX_HOLD(MAX_HOLD), .ID_W(ID_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .mode(mode),
        .grant(grant), .grant_valid(grant_valid),
        .grant_id(grant_id), .timeout_evt(timeout_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // First eligible requester by the rules of the selected mode; -1 if none.
    function automatic int pick(input logic [N-1:0] c, input bit md, input int start);
        for (int k = 0; k < int'(N); k++) begin
            int i;
            i = md ? (start + k) % int'(N) : k;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    // Model update on each active edge, from the inputs the DUT also samples.
    always @(posedge clk) begin
        logic [N-1:0] others;
        int w;
        exp_to = 1'b0;
        if (rst) begin
            owner   = -1;
            held    = 0;
            rr_next = 0;
        end else if (owner < 0 || !req[owner]) begin
            others = req;
            if (owner >= 0) others[owner] = 1'b0;
            w = pick(others, mode, rr_next);
            owner = w;
            held  = (w >= 0) ? 1 : 0;
            if (w >= 0) rr_next = (w + 1) % int'(N);
        end else begin
            others = req;
            others[owner] = 1'b0;
            if (others != '0 && MAX_HOLD != 0 && held >= int'(MAX_HOLD)) begin
                w = pick(others, mode, rr_next);
                owner   = w;
                held    = 1;
                rr_next = (w + 1) % int'(N);
                exp_to  = 1'b1;
            end else begin
                held++;
            end
        end
    end

    // Compare outputs away from the edge, then present the next inputs.
    task automatic step(input logic [N-1:0] r, input logic m, input logic rs);
        logic [N-1:0] eg;
        @(negedge clk);
        eg = (owner >= 0) ? N'(1) << owner : '0;
        chk("grant",       32'(grant),       32'(eg));
        chk("grant_valid", 32'(grant_valid), 32'(owner >= 0));
        chk("grant_id",    32'(grant_id),    (owner >= 0) ? 32'(owner) : 32'd0);
        chk("timeout_evt", 32'(timeout_evt), 32'(exp_to));
        if (timeout_evt) to_seen++;
        req  = r;
        mode = m;
        rst  = rs;
    endtask

    task automatic hold_in(input logic [N-1:0] r, input logic m, input int cycles);
        for (int i = 0; i < cycles; i++) step(r, m, 1'b0);
    endtask

    task automatic do_reset();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [N-1:0] r;
        logic         m;
        rst  = 1'b1;
        req  = '0;
        mode = 1'b0;

        // Reset values, checked against constants.
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_id",    32'(grant_id), 32'd0);
        chk("rst_to",    32'(timeout_evt), 32'd0);
        rst = 1'b0;

        // Single requesters in turn: zero-bubble handover.
        hold_in(4'b0001, 1'b0, 4);
        hold_in(4'b0010, 1'b0, 4);
        hold_in(4'b0100, 1'b0, 4);
        hold_in(4'b1000, 1'b0, 4);
        do_reset();

        // Timeout rotation under fixed priority: three forced handovers in 32 cycles.
        to_seen = 0;
        hold_in(4'b0111, 1'b0, 32);
        step('0, 1'b0, 1'b0);
        chk("fixed_timeouts", 32'(to_seen), 32'd3);
        do_reset();

        // Round-robin over all four with pointer wrap.
        hold_in(4'b1111, 1'b1, 40);
        do_reset();

        // Two contenders, then a lone requester that must never be timed out.
        hold_in(4'b1010, 1'b0, 24);
        step(4'b0100, 1'b0, 1'b0);
        to_seen = 0;
        hold_in(4'b0100, 1'b0, 20);
        chk("lone_no_timeout", 32'(to_seen), 32'd0);
        chk("lone_grant", 32'(grant), 32'b0100);
        do_reset();

        // Owner drops its request: next owner with no idle cycle.
        hold_in(4'b0011, 1'b1, 4);
        hold_in(4'b0010, 1'b1, 4);
        chk("drop_grant", 32'(grant), 32'b0010);
        do_reset();

        // Reset in the middle of a lock, then round-robin from pointer 0.
        hold_in(4'b0100, 1'b0, 7);
        step(4'b0100, 1'b0, 1'b1);
        step(4'b0110, 1'b1, 1'b0);
        step(4'b0110, 1'b1, 1'b0);
        chk("post_rst_grant", 32'(grant), 32'b0010);

        // Randomized traffic with persistent requests and occasional resets.
        r = '0;
        m = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) r = N'($urandom);
            if ($urandom_range(31) == 0) m = ~m;
            step(r, m, ($urandom_range(127) == 0));
        end
        step('0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
